// File: rtl/rk8e_sequencer.sv
// RK8-E command sequencer: validates DLAG commands, drives the SD sector
// engine, and owns status, per-drive write locks and the done interrupt.
module rk8e_sequencer #(
  parameter int MAX_CYL = 203,
  parameter int TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        cmd_go,
  input  logic        status_clr,
  input  logic [0:11] cmd_reg,
  input  logic [0:11] dar,
  input  logic [0:11] car,
  output logic [1:0]  sd_op,
  output logic        sd_start,
  output logic [14:0] sd_disk_addr,
  output logic [14:0] sd_mem_addr,
  output logic        sd_len,
  input  logic        sd_done,
  input  logic        sd_err,
  output logic [0:11] status,
  output logic        busy,
  output logic        irq,
  output logic [3:0]  write_lock
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [0:11]   cmd_q, cmd_d;
  logic [0:11]   dar_q, dar_d;
  logic [0:11]   car_q, car_d;
  logic [0:11]   status_q, status_d;
  logic [0:11]   set_m;
  logic [1:0]    sd_op_q, sd_op_d;
  logic          sd_start_q, sd_start_d;
  logic          busy_q, busy_d;
  logic          irq_q, irq_d;
  logic [3:0]    wl_q, wl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]    op;
  logic [1:0]    drv;
  logic [7:0]    cyl;
  logic          cyl_err;

  assign op      = cmd_q[0:2];
  assign drv     = cmd_q[9:10];
  assign cyl     = {cmd_q[11], dar_q[0:6]};
  assign cyl_err = ({24'd0, cyl} > 32'(MAX_CYL));

  // Next-state, status set mask and output computation.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    dar_d      = dar_q;
    car_d      = car_q;
    sd_op_d    = sd_op_q;
    sd_start_d = 1'b0;
    cnt_d      = cnt_q;
    wl_d       = wl_q;
    set_m      = '0;

    if (cmd_go && state_q != S_IDLE) set_m[5] = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_go) begin
          cmd_d   = cmd_reg;
          dar_d   = dar;
          car_d   = car;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_DONE;
        if (cyl_err) begin
          set_m[11] = 1'b1;
        end else begin
          case (op)
            3'd0, 3'd1: begin
              sd_op_d    = OP_READ;
              sd_start_d = 1'b1;
              cnt_d      = '0;
              state_d    = S_ISSUE;
            end
            3'd2: wl_d[drv] = 1'b1;
            3'd3: ;
            3'd4, 3'd5: begin
              if (wl_q[drv]) begin
                set_m[7] = 1'b1;
              end else begin
                sd_op_d    = OP_WRITE;
                sd_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_ISSUE;
              end
            end
            default: set_m[10] = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sd_done) begin
          if (sd_err) set_m[10] = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          set_m[9] = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        set_m[0] = 1'b1;
        sd_op_d  = OP_NOP;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    status_d = (status_clr ? 12'd0 : status_q) | set_m;
    busy_d   = (state_d != S_IDLE);
    irq_d    = status_q[0] & cmd_q[3];

    if (clear) begin
      state_d    = S_IDLE;
      cmd_d      = '0;
      dar_d      = '0;
      car_d      = '0;
      sd_op_d    = OP_NOP;
      sd_start_d = 1'b0;
      cnt_d      = '0;
      wl_d       = '0;
      status_d   = '0;
      busy_d     = 1'b0;
      irq_d      = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      dar_q      <= '0;
      car_q      <= '0;
      sd_op_q    <= OP_NOP;
      sd_start_q <= 1'b0;
      cnt_q      <= '0;
      wl_q       <= '0;
      status_q   <= '0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      dar_q      <= dar_d;
      car_q      <= car_d;
      sd_op_q    <= sd_op_d;
      sd_start_q <= sd_start_d;
      cnt_q      <= cnt_d;
      wl_q       <= wl_d;
      status_q   <= status_d;
      busy_q     <= busy_d;
      irq_q      <= irq_d;
    end
  end

  assign sd_op        = sd_op_q;
  assign sd_start     = sd_start_q;
  assign sd_disk_addr = {cmd_q[9:11], dar_q};
  assign sd_mem_addr  = {cmd_q[6:8], car_q};
  assign sd_len       = cmd_q[5];
  assign status       = status_q;
  assign busy         = busy_q;
  assign irq          = irq_q;
  assign write_lock   = wl_q;

endmodule
